// File: rtl/wb_sram_bank_bridge.sv
// Wishbone slave bridging a decoded address window onto NUM_BANKS dual-port SRAM macros
// (port 0 read/write, port 1 read-only) with a programmable read-capture latency.
module wb_sram_bank_bridge #(
  parameter int          NUM_BANKS = 4,
  parameter int          ADDR_W    = 9,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic                        wb_clk_i,
  input  logic                        resetn,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [DATA_W/8-1:0]         wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [DATA_W-1:0]           wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [DATA_W-1:0]           wbs_dat_o,
  output logic [NUM_BANKS-1:0]        csb0,
  output logic                        web0,
  output logic [DATA_W/8-1:0]         wmask0,
  output logic [ADDR_W-1:0]           addr0,
  output logic [DATA_W-1:0]           din0,
  output logic [NUM_BANKS-1:0]        csb1,
  output logic [ADDR_W-1:0]           addr1,
  input  logic [NUM_BANKS*DATA_W-1:0] dout0,
  input  logic [NUM_BANKS*DATA_W-1:0] dout1
);

  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WM_W    = DATA_W / 8;
  localparam int WIN_LSB = ADDR_W + BANK_W + 3;
  localparam int CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, ACK} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BANK_W-1:0]    bank_reg, bank_next;
  logic                 port_reg, port_next;
  logic                 we_reg, we_next;
  logic                 null_reg, null_next;
  logic                 abort_reg, abort_next;
  logic [DATA_W-1:0]    rdata_reg, rdata_next;
  logic [NUM_BANKS-1:0] csb0_reg, csb0_next;
  logic [NUM_BANKS-1:0] csb1_reg, csb1_next;
  logic                 web0_reg, web0_next;
  logic [WM_W-1:0]      wmask0_reg, wmask0_next;
  logic [ADDR_W-1:0]    addr0_reg, addr0_next;
  logic [DATA_W-1:0]    din0_reg, din0_next;
  logic [ADDR_W-1:0]    addr1_reg, addr1_next;

  logic [ADDR_W-1:0]    word_dec;
  logic [BANK_W-1:0]    bank_dec;
  logic                 port_dec;
  logic                 hit;
  logic                 bank_ok;
  logic                 req;
  logic [NUM_BANKS-1:0] bank_hot;
  logic [DATA_W-1:0]    cap_data;
  logic                 unused_adr;

  assign word_dec   = wbs_adr_i[ADDR_W+1:2];
  assign bank_dec   = wbs_adr_i[ADDR_W+2 +: BANK_W];
  assign port_dec   = wbs_adr_i[ADDR_W+BANK_W+2];
  assign hit        = (wbs_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign bank_ok    = (int'(bank_dec) < NUM_BANKS);
  assign req        = wbs_stb_i & wbs_cyc_i & hit;
  assign unused_adr = ^wbs_adr_i[1:0];

  // An out-of-range bank number leaves every bit clear, so it selects nothing.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_hot
    assign bank_hot[gi] = (bank_dec == BANK_W'(gi));
  end

  always_comb begin
    cap_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(bank_reg) == b) begin
        cap_data = port_reg ? dout1[b*DATA_W +: DATA_W] : dout0[b*DATA_W +: DATA_W];
      end
    end
    if (null_reg) begin
      cap_data = '0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bank_next   = bank_reg;
    port_next   = port_reg;
    we_next     = we_reg;
    null_next   = null_reg;
    abort_next  = abort_reg;
    rdata_next  = rdata_reg;
    csb0_next   = csb0_reg;
    csb1_next   = csb1_reg;
    web0_next   = web0_reg;
    wmask0_next = wmask0_reg;
    addr0_next  = addr0_reg;
    din0_next   = din0_reg;
    addr1_next  = addr1_reg;

    // Once cyc drops the master has abandoned the cycle; remember it so no late ack escapes.
    if (state_reg != IDLE && !wbs_cyc_i) begin
      abort_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (req) begin
          bank_next  = bank_dec;
          port_next  = port_dec;
          we_next    = wbs_we_i;
          null_next  = !bank_ok || (port_dec && wbs_we_i);
          abort_next = 1'b0;
          if (!port_dec && bank_ok) begin
            csb0_next   = ~bank_hot;
            web0_next   = !wbs_we_i;
            addr0_next  = word_dec;
            wmask0_next = wbs_we_i ? wbs_sel_i : '0;
            if (wbs_we_i) begin
              din0_next = wbs_dat_i;
            end
          end else if (port_dec && !wbs_we_i && bank_ok) begin
            csb1_next  = ~bank_hot;
            addr1_next = word_dec;
          end
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        csb0_next = '1;
        csb1_next = '1;
        web0_next = 1'b1;
        if (we_reg) begin
          state_next = ACK;
        end else if (RD_LAT == 1) begin
          state_next = CAPT;
        end else begin
          cnt_next   = CNT_W'(RD_LAT - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = CAPT;
        end
      end
      CAPT: begin
        rdata_next = cap_data;
        state_next = ACK;
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bank_reg   <= '0;
      port_reg   <= 1'b0;
      we_reg     <= 1'b0;
      null_reg   <= 1'b0;
      abort_reg  <= 1'b0;
      rdata_reg  <= '0;
      csb0_reg   <= '1;
      csb1_reg   <= '1;
      web0_reg   <= 1'b1;
      wmask0_reg <= '0;
      addr0_reg  <= '0;
      din0_reg   <= '0;
      addr1_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bank_reg   <= bank_next;
      port_reg   <= port_next;
      we_reg     <= we_next;
      null_reg   <= null_next;
      abort_reg  <= abort_next;
      rdata_reg  <= rdata_next;
      csb0_reg   <= csb0_next;
      csb1_reg   <= csb1_next;
      web0_reg   <= web0_next;
      wmask0_reg <= wmask0_next;
      addr0_reg  <= addr0_next;
      din0_reg   <= din0_next;
      addr1_reg  <= addr1_next;
    end
  end

  assign wbs_ack_o = (state_reg == ACK) && wbs_cyc_i && !abort_reg;
  assign wbs_dat_o = (state_reg == ACK && !we_reg) ? rdata_reg : '0;
  assign csb0      = csb0_reg;
  assign csb1      = csb1_reg;
  assign web0      = web0_reg;
  assign wmask0    = wmask0_reg;
  assign addr0     = addr0_reg;
  assign din0      = din0_reg;
  assign addr1     = addr1_reg;

endmodule

// File: tb/tb_wb_sram_bank_bridge.sv
// Directed bench: table of Wishbone transactions against an SRAM model, plus hand
// sequences for miss, abort, long read latency and reset mid-operation.
module tb_wb_sram_bank_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        stb, cyc, we, stb_b, cyc_b;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;

  logic         ack_a, web0_a;
  logic [31:0]  dat_a, din0_a;
  logic [3:0]   csb0_a, csb1_a, wmask0_a;
  logic [8:0]   addr0_a, addr1_a;
  logic [127:0] dout0_a, dout1_a;

  logic         ack_b, web0_b;
  logic [31:0]  dat_b, din0_b;
  logic [3:0]   csb0_b, csb1_b, wmask0_b;
  logic [8:0]   addr0_b, addr1_b;
  logic [127:0] dout0_b, dout1_b;

  wb_sram_bank_bridge dut_a (
    .wb_clk_i(clk), .resetn(resetn),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a), .wbs_dat_o(dat_a),
    .csb0(csb0_a), .web0(web0_a), .wmask0(wmask0_a), .addr0(addr0_a), .din0(din0_a),
    .csb1(csb1_a), .addr1(addr1_a), .dout0(dout0_a), .dout1(dout1_a)
  );

  wb_sram_bank_bridge #(.RD_LAT(3)) dut_b (
    .wb_clk_i(clk), .resetn(resetn),
    .wbs_stb_i(stb_b), .wbs_cyc_i(cyc_b), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b), .wbs_dat_o(dat_b),
    .csb0(csb0_b), .web0(web0_b), .wmask0(wmask0_b), .addr0(addr0_b), .din0(din0_b),
    .csb1(csb1_b), .addr1(addr1_b), .dout0(dout0_b), .dout1(dout1_b)
  );

  // SRAM model for dut_a: one-cycle read latency on both ports, byte-masked writes.
  logic [31:0] mem [4][512];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int b = 0; b < 4; b++) begin
        for (int w = 0; w < 512; w++) mem[b][w] <= 32'hC000_0000 | (b << 16) | w;
        dout0_a[b*32 +: 32] <= 32'hD000_0000 | b;
        dout1_a[b*32 +: 32] <= 32'hE000_0000 | b;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!csb0_a[b]) begin
          if (!web0_a) begin
            for (int k = 0; k < 4; k++)
              if (wmask0_a[k]) mem[b][addr0_a][k*8 +: 8] <= din0_a[k*8 +: 8];
          end else begin
            dout0_a[b*32 +: 32] <= mem[b][addr0_a];
          end
        end
        if (!csb1_a[b]) dout1_a[b*32 +: 32] <= mem[b][addr1_a];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [3:0]  csb0;
    logic [3:0]  csb1;
    logic        web0;
    logic        p1;
    logic        chk_addr;
    logic [8:0]  addr;
    logic [3:0]  wmask;
    int          ack_cyc;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs [11];

  logic [3:0]  t1_csb0, t1_csb1, t1_wmask;
  logic        t1_web0;
  logic [8:0]  t1_addr0, t1_addr1;
  logic [31:0] t1_din0, got_rdat;
  int          got_ack;

  // Called #1 after a rising edge with dut_a in IDLE; returns likewise.
  task automatic do_txn(input logic t_we, input logic [31:0] t_adr, input logic [3:0] t_sel,
                        input logic [31:0] t_dat);
    adr = t_adr; we = t_we; sel = t_sel; wdat = t_dat; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    t1_csb0 = csb0_a; t1_csb1 = csb1_a; t1_web0 = web0_a; t1_wmask = wmask0_a;
    t1_addr0 = addr0_a; t1_addr1 = addr1_a; t1_din0 = din0_a;
    got_ack = 0; got_rdat = '0;
    for (int k = 2; k <= 20 && got_ack == 0; k++) begin
      @(posedge clk); #1;
      if (ack_a) begin
        got_ack = k;
        got_rdat = dat_a;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  int bad;
  logic [3:0] lat_acks;

  initial begin
    vecs[0]  = '{1'b1, 32'h3000_0804, 4'hF, 32'hDEAD_BEEF, 4'b1101, 4'b1111, 1'b0, 1'b0, 1'b1, 9'd1,   4'hF, 2, 32'h0};
    vecs[1]  = '{1'b0, 32'h3000_0804, 4'h0, 32'h0,         4'b1101, 4'b1111, 1'b1, 1'b0, 1'b1, 9'd1,   4'h0, 3, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h3000_0804, 4'h5, 32'h1122_3344, 4'b1101, 4'b1111, 1'b0, 1'b0, 1'b1, 9'd1,   4'h5, 2, 32'h0};
    vecs[3]  = '{1'b0, 32'h3000_0804, 4'h0, 32'h0,         4'b1101, 4'b1111, 1'b1, 1'b0, 1'b1, 9'd1,   4'h0, 3, 32'hDE22_BE44};
    vecs[4]  = '{1'b1, 32'h3000_0808, 4'hF, 32'h55AA_55AA, 4'b1101, 4'b1111, 1'b0, 1'b0, 1'b1, 9'd2,   4'hF, 2, 32'h0};
    vecs[5]  = '{1'b0, 32'h3000_0808, 4'h0, 32'h0,         4'b1101, 4'b1111, 1'b1, 1'b0, 1'b1, 9'd2,   4'h0, 3, 32'h55AA_55AA};
    vecs[6]  = '{1'b0, 32'h3000_2804, 4'h0, 32'h0,         4'b1111, 4'b1101, 1'b1, 1'b1, 1'b1, 9'd1,   4'h0, 3, 32'hDE22_BE44};
    vecs[7]  = '{1'b1, 32'h3000_2804, 4'hF, 32'h0123_4567, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 9'd0,   4'h0, 2, 32'h0};
    vecs[8]  = '{1'b0, 32'h3000_1FFF, 4'h0, 32'h0,         4'b0111, 4'b1111, 1'b1, 1'b0, 1'b1, 9'h1FF, 4'h0, 3, 32'hC003_01FF};
    vecs[9]  = '{1'b0, 32'h3000_2000, 4'h0, 32'h0,         4'b1111, 4'b1110, 1'b1, 1'b1, 1'b1, 9'd0,   4'h0, 3, 32'hC000_0000};
    vecs[10] = '{1'b0, 32'h3000_3FFC, 4'h0, 32'h0,         4'b1111, 4'b0111, 1'b1, 1'b1, 1'b1, 9'h1FF, 4'h0, 3, 32'hC003_01FF};

    resetn = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; stb_b = 1'b0; cyc_b = 1'b0;
    sel = '0; adr = '0; wdat = '0; dout0_b = '0; dout1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csb0", 32'(csb0_a), 32'hF);
    check("rst_csb1", 32'(csb1_a), 32'hF);
    check("rst_web0", 32'(web0_a), 32'h1);
    check("rst_wmask0", 32'(wmask0_a), 32'h0);
    check("rst_addr0", 32'(addr0_a), 32'h0);
    check("rst_din0", din0_a, 32'h0);
    check("rst_addr1", 32'(addr1_a), 32'h0);
    check("rst_ack", 32'(ack_a), 32'h0);
    check("rst_dat", dat_a, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat);
      check($sformatf("v%0d_csb0", i), 32'(t1_csb0), 32'(vecs[i].csb0));
      check($sformatf("v%0d_csb1", i), 32'(t1_csb1), 32'(vecs[i].csb1));
      check($sformatf("v%0d_web0", i), 32'(t1_web0), 32'(vecs[i].web0));
      if (vecs[i].chk_addr)
        check($sformatf("v%0d_addr", i), vecs[i].p1 ? 32'(t1_addr1) : 32'(t1_addr0), 32'(vecs[i].addr));
      if (!vecs[i].p1)
        check($sformatf("v%0d_wmask0", i), 32'(t1_wmask), 32'(vecs[i].wmask));
      if (vecs[i].we && !vecs[i].p1)
        check($sformatf("v%0d_din0", i), t1_din0, vecs[i].wdat);
      check($sformatf("v%0d_ack_cycle", i), 32'(got_ack), 32'(vecs[i].ack_cyc));
      check($sformatf("v%0d_rdata", i), got_rdat, vecs[i].rdat);
    end

    // Miss: outside the window, nothing may happen for 20 cycles.
    adr = 32'h3100_0000; we = 1'b0; stb = 1'b1; cyc = 1'b1; bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack_a || csb0_a != 4'hF || csb1_a != 4'hF) bad++;
    end
    check("miss_quiet_cycles", 32'(bad), 32'h0);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;

    // Abort: cyc dropped in T2 suppresses the ack.
    adr = 32'h3000_0804; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    check("abort_t1_csb0", 32'(csb0_a), 32'hD);
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_a) bad++;
    end
    check("abort_no_ack", 32'(bad), 32'h0);
    do_txn(1'b0, 32'h3000_0804, 4'h0, 32'h0);
    check("after_abort_ack_cycle", 32'(got_ack), 32'd3);
    check("after_abort_rdata", got_rdat, 32'hDE22_BE44);

    // RD_LAT=3 on dut_b: ack in T5, data sampled at end of T4 only.
    adr = 32'h3000_0804; we = 1'b0; stb_b = 1'b1; cyc_b = 1'b1;
    @(posedge clk); #1;
    check("lat_t1_csb0", 32'(csb0_b), 32'hD);
    dout0_b[63:32] = 32'h1111_1111;
    @(posedge clk); #1; lat_acks[0] = ack_b;
    @(posedge clk); #1; lat_acks[1] = ack_b;
    @(posedge clk); #1; lat_acks[2] = ack_b;
    dout0_b[63:32] = 32'hCAFE_F00D;
    @(posedge clk); #1; lat_acks[3] = ack_b;
    check("lat_ack_t2_to_t5", 32'(lat_acks), 32'h8);
    check("lat_rdata", dat_b, 32'hCAFE_F00D);
    dout0_b[63:32] = 32'hBAD0_BAD0;
    #1;
    check("lat_rdata_hold", dat_b, 32'hCAFE_F00D);
    stb_b = 1'b0; cyc_b = 1'b0;
    @(posedge clk); #1;

    // Reset asserted mid-read releases every chip select at once.
    adr = 32'h3000_2804; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    check("rstmid_t1_csb1", 32'(csb1_a), 32'hD);
    #2 resetn = 1'b0;
    #1;
    check("rstmid_csb0", 32'(csb0_a), 32'hF);
    check("rstmid_csb1", 32'(csb1_a), 32'hF);
    stb = 1'b0; cyc = 1'b0; bad = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack_a) bad++;
    end
    check("rstmid_no_ack", 32'(bad), 32'h0);
    resetn = 1'b1;
    check("rel_web0", 32'(web0_a), 32'h1);
    check("rel_addr1", 32'(addr1_a), 32'h0);
    check("rel_dat", dat_a, 32'h0);
    do_txn(1'b0, 32'h3000_0804, 4'h0, 32'h0);
    check("rel_first_csb0", 32'(t1_csb0), 32'hD);
    check("rel_first_ack_cycle", 32'(got_ack), 32'd3);
    check("rel_first_rdata", got_rdat, 32'hC001_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
